// File: rtl/router_rr_param_if.sv
// Port bundle for router_rr_param: flat per-port flit buses, handshakes and the drop counter.
// The router connects through the slave modport; the traffic source/sink uses master.
interface router_rr_param_if #(
    parameter int NPORTS = 4,
    parameter int DATA_W = 32,
    parameter int DROP_W = 16
);
    logic [NPORTS*DATA_W-1:0] in_data;
    logic [NPORTS-1:0]        in_valid;
    logic [NPORTS-1:0]        in_full;
    logic [NPORTS*DATA_W-1:0] out_data;
    logic [NPORTS-1:0]        out_valid;
    logic [NPORTS-1:0]        out_full;
    logic [DROP_W-1:0]        drop_cnt;

    modport master (
        output in_data, in_valid, out_full,
        input  in_full, out_data, out_valid, drop_cnt
    );

    modport slave (
        input  in_data, in_valid, out_full,
        output in_full, out_data, out_valid, drop_cnt
    );
endinterface

// File: rtl/router_rr_param.sv
// N-port input-buffered mesh router: per-input FIFO, table routing on the head flit,
// per-output round-robin arbitration with downstream backpressure, and an unroutable-flit counter.

module router_rr_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              empty_o,
    output logic              full_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    // Full is judged on the registered count, so a pop never opens room for a same-cycle push.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + PTR_W'(1);
        if (do_pop)  rd_d = rd_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

module router_rr_param #(
    parameter int NPORTS = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8,
    parameter int PORT_W = 3,
    parameter logic [(2**ADDR_W)*PORT_W-1:0] ROUTE_TABLE = '0,
    parameter int DROP_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    router_rr_param_if.slave   bus
);
    localparam int IDX_W  = $clog2(NPORTS);
    localparam int NCNT_W = $clog2(NPORTS + 1);
    localparam int SUM_W  = DROP_W + NCNT_W;

    logic [NPORTS-1:0][DATA_W-1:0] in_data, head;
    logic [NPORTS-1:0][DATA_W-1:0] out_data_q, out_data_d;
    logic [NPORTS-1:0]             out_valid_q, out_valid_d;
    logic [NPORTS-1:0]             empty, full, pop, drop;
    logic [NPORTS-1:0][PORT_W-1:0] req_port;
    logic [NPORTS-1:0][NPORTS-1:0] gnt;
    logic [NPORTS-1:0][IDX_W-1:0]  ptr_q, ptr_d;
    logic [DROP_W-1:0]             drop_cnt_q, drop_cnt_d;
    logic [NCNT_W-1:0]             ndrop;
    logic [SUM_W-1:0]              drop_sum;
    int                            scan;

    assign in_data       = bus.in_data;
    assign bus.in_full   = full;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.drop_cnt  = drop_cnt_q;

    for (genvar p = 0; p < NPORTS; p++) begin : g_in
        router_rr_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (bus.in_valid[p]),
            .data_i  (in_data[p]),
            .pop_i   (pop[p]),
            .head_o  (head[p]),
            .empty_o (empty[p]),
            .full_o  (full[p])
        );

        assign req_port[p] = ROUTE_TABLE[int'(head[p][ADDR_W-1:0])*PORT_W +: PORT_W];
        // Unroutable heads leave immediately without competing for any output.
        assign drop[p]     = !empty[p] && (int'(req_port[p]) >= NPORTS);
    end

    // Each output scans its requesters starting at its own pointer, wrapping at NPORTS.
    always_comb begin
        gnt         = '0;
        ptr_d       = ptr_q;
        out_valid_d = '0;
        out_data_d  = '0;
        scan        = 0;
        for (int o = 0; o < NPORTS; o++) begin
            if (!bus.out_full[o]) begin
                for (int k = 0; k < NPORTS; k++) begin
                    scan = int'(ptr_q[o]) + k;
                    if (scan >= NPORTS) scan = scan - NPORTS;
                    if (!out_valid_d[o] && !empty[scan] && int'(req_port[scan]) == o) begin
                        out_valid_d[o] = 1'b1;
                        out_data_d[o]  = head[scan];
                        gnt[o][scan]   = 1'b1;
                        ptr_d[o]       = (scan == NPORTS - 1) ? '0 : IDX_W'(scan + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        pop = drop;
        for (int o = 0; o < NPORTS; o++) pop = pop | gnt[o];
    end

    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NPORTS; i++) ndrop = ndrop + NCNT_W'(drop[i]);
        drop_sum   = SUM_W'(drop_cnt_q) + SUM_W'(ndrop);
        drop_cnt_d = (|drop_sum[SUM_W-1:DROP_W]) ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end
endmodule

// File: tb/tb_router_rr_param.sv
// Bench for router_rr_param: directed table and sequences plus random traffic,
// all cross-checked every cycle against a queue-based model of the routing rules.
module tb_router_rr_param;
    localparam int NP    = 4;
    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int PW    = 3;
    localparam int DROPW = 4;
    localparam logic [8*PW-1:0] ROUTE = {3'd5, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2, 3'd1, 3'd0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NP-1:0]         iv = '0;
    logic [NP-1:0]         ofull = '0;
    logic [NP-1:0][DW-1:0] idata = '0;
    logic [NP-1:0][DW-1:0] odata;

    int errors = 0;
    int checks = 0;

    router_rr_param_if #(.NPORTS(NP), .DATA_W(DW), .DROP_W(DROPW)) bus();

    router_rr_param #(
        .NPORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
        .PORT_W(PW), .ROUTE_TABLE(ROUTE), .DROP_W(DROPW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.in_valid = iv;
    assign bus.in_data  = idata;
    assign bus.out_full = ofull;
    assign odata        = bus.out_data;

    always #5 clk = ~clk;

    // Reference model: one queue per input, one pointer per output.
    logic [DW-1:0]         mq [NP][$];
    int                    mptr [NP];
    int                    mdrop = 0;
    logic [NP-1:0]         m_valid = '0;
    logic [NP-1:0][DW-1:0] m_data = '0;

    function automatic int route(input logic [AW-1:0] d);
        case (d)
            3'd1:    return 1;
            3'd2:    return 2;
            3'd3:    return 3;
            3'd7:    return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [DW-1:0] flit(input int dst, input int tag);
        return (DW'(tag) << 8) | DW'(dst);
    endfunction

    function automatic int head_route(input int i);
        logic [DW-1:0] h;
        if (mq[i].size() == 0) return -1;
        h = mq[i][0];
        return route(h[AW-1:0]);
    endfunction

    task automatic model_step();
        bit drop [NP];
        bit popi [NP];
        bit acc  [NP];
        int i;
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) begin
                mq[p].delete();
                mptr[p] = 0;
            end
            m_valid = '0;
            m_data  = '0;
            mdrop   = 0;
            return;
        end
        for (int p = 0; p < NP; p++) begin
            acc[p]  = iv[p] && (mq[p].size() < DEPTH);
            drop[p] = (head_route(p) >= NP);
            popi[p] = drop[p];
        end
        m_valid = '0;
        m_data  = '0;
        for (int o = 0; o < NP; o++) begin
            if (!ofull[o]) begin
                for (int k = 0; k < NP; k++) begin
                    i = (mptr[o] + k) % NP;
                    if (!m_valid[o] && head_route(i) == o) begin
                        m_valid[o] = 1'b1;
                        m_data[o]  = mq[i][0];
                        popi[i]    = 1'b1;
                        mptr[o]    = (i + 1) % NP;
                    end
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (popi[p]) void'(mq[p].pop_front());
            if (acc[p])  mq[p].push_back(idata[p]);
            if (drop[p] && mdrop < (2**DROPW) - 1) mdrop++;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [NP-1:0] exp_full;
        model_step();
        @(posedge clk);
        #1;
        chk("model_out_valid", 64'(bus.out_valid), 64'(m_valid));
        for (int o = 0; o < NP; o++) chk("model_out_data", 64'(odata[o]), 64'(m_data[o]));
        for (int p = 0; p < NP; p++) exp_full[p] = (mq[p].size() == DEPTH);
        chk("model_in_full", 64'(bus.in_full), 64'(exp_full));
        chk("model_drop_cnt", 64'(bus.drop_cnt), 64'(mdrop));
    endtask

    task automatic do_reset();
        iv    = '0;
        ofull = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int            src;
        int            dst;
        logic [NP-1:0] exp_v;
        int            exp_o;
    } vec_t;

    vec_t tbl [10];
    int   exp_drops;

    initial begin
        tbl[0] = '{0, 2, 4'b0100, 2};
        tbl[1] = '{0, 0, 4'b0001, 0};
        tbl[2] = '{1, 1, 4'b0010, 1};
        tbl[3] = '{2, 2, 4'b0100, 2};
        tbl[4] = '{3, 3, 4'b1000, 3};
        tbl[5] = '{2, 4, 4'b0001, 0};
        tbl[6] = '{3, 5, 4'b0001, 0};
        tbl[7] = '{0, 6, 4'b0001, 0};
        tbl[8] = '{1, 7, 4'b0000, -1};
        tbl[9] = '{3, 1, 4'b0010, 1};

        do_reset();
        chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset_in_full", 64'(bus.in_full), 64'(0));
        chk("reset_drop_cnt", 64'(bus.drop_cnt), 64'(0));

        // Minimum latency: present in cycle 0, visible after two edges.
        iv[0] = 1'b1; idata[0] = 32'h0000_0012;
        step();
        iv = '0;
        chk("lat_cycle1_valid", 64'(bus.out_valid), 64'(0));
        step();
        chk("lat_cycle2_valid", 64'(bus.out_valid), 64'(4'b0100));
        chk("lat_cycle2_data", 64'(odata[2]), 64'(32'h12));
        for (int o = 0; o < NP; o++)
            if (o != 2) chk("lat_other_data", 64'(odata[o]), 64'(0));
        step();

        // Routing table, including U-turns and a drop.
        exp_drops = 0;
        for (int n = 0; n < 10; n++) begin
            iv = '0;
            iv[tbl[n].src] = 1'b1;
            idata[tbl[n].src] = flit(tbl[n].dst, n + 1);
            step();
            iv = '0;
            chk("tbl_early_valid", 64'(bus.out_valid), 64'(0));
            step();
            chk("tbl_valid", 64'(bus.out_valid), 64'(tbl[n].exp_v));
            if (tbl[n].exp_o >= 0) chk("tbl_data", 64'(odata[tbl[n].exp_o]), 64'(flit(tbl[n].dst, n + 1)));
            else exp_drops++;
            chk("tbl_drop_cnt", 64'(bus.drop_cnt), 64'(exp_drops));
        end

        // Round-robin on output 1 among inputs 0, 1, 3.
        do_reset();
        ofull[1] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            iv = 4'b1011;
            idata[0] = flit(1, 0*16 + n);
            idata[1] = flit(1, 1*16 + n);
            idata[3] = flit(1, 3*16 + n);
            step();
        end
        iv = '0;
        ofull = '0;
        for (int k = 0; k < 12; k++) begin
            int src;
            src = (k % 3 == 0) ? 0 : (k % 3 == 1) ? 1 : 3;
            step();
            chk("rr_valid", 64'(bus.out_valid[1]), 64'(1));
            chk("rr_order", 64'(odata[1]), 64'(flit(1, src*16 + k/3)));
        end
        step();
        chk("rr_done", 64'(bus.out_valid), 64'(0));

        // Backpressure on output 3 with input 2 filling to full.
        do_reset();
        ofull[3] = 1'b1;
        for (int n = 0; n < 9; n++) begin
            iv[2] = 1'b1;
            idata[2] = flit(3, 'h100 + n);
            step();
            chk("bp_held", 64'(bus.out_valid[3]), 64'(0));
            if (n == 7) chk("bp_in_full", 64'(bus.in_full[2]), 64'(1));
        end
        iv = '0;
        step();
        chk("bp_held_last", 64'(bus.out_valid[3]), 64'(0));
        ofull = '0;
        for (int n = 0; n < 8; n++) begin
            step();
            chk("bp_valid", 64'(bus.out_valid[3]), 64'(1));
            chk("bp_data", 64'(odata[3]), 64'(flit(3, 'h100 + n)));
        end
        step();
        chk("bp_ninth_lost", 64'(bus.out_valid[3]), 64'(0));

        // Drops and counter saturation.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            iv[1] = 1'b1;
            idata[1] = flit(7, n);
            step();
        end
        iv = '0;
        step();
        step();
        chk("drop_three", 64'(bus.drop_cnt), 64'(3));
        for (int n = 0; n < (2**DROPW) + 5; n++) begin
            iv[1] = 1'b1;
            idata[1] = flit(7, n);
            step();
        end
        iv = '0;
        repeat (3) step();
        chk("drop_saturate", 64'(bus.drop_cnt), 64'((2**DROPW) - 1));

        // Push while full with a simultaneous pop is rejected; next push lands.
        do_reset();
        ofull[0] = 1'b1;
        for (int n = 0; n < 8; n++) begin
            iv[3] = 1'b1;
            idata[3] = flit(0, 'h200 + n);
            step();
        end
        chk("pp_full", 64'(bus.in_full[3]), 64'(1));
        ofull = '0;
        idata[3] = flit(0, 'h2AA);
        step();
        chk("pp_first_pop", 64'(odata[0]), 64'(flit(0, 'h200)));
        chk("pp_not_full", 64'(bus.in_full[3]), 64'(0));
        idata[3] = flit(0, 'h2BB);
        step();
        iv = '0;
        chk("pp_second_pop", 64'(odata[0]), 64'(flit(0, 'h201)));
        for (int n = 2; n < 8; n++) begin
            step();
            chk("pp_drain", 64'(odata[0]), 64'(flit(0, 'h200 + n)));
        end
        step();
        chk("pp_accepted", 64'(odata[0]), 64'(flit(0, 'h2BB)));
        step();
        chk("pp_empty", 64'(bus.out_valid[0]), 64'(0));

        // Reset in the middle of traffic.
        iv = 4'b1111;
        for (int p = 0; p < NP; p++) idata[p] = flit(p, 'h300 + p);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_full", 64'(bus.in_full), 64'(0));
        for (int o = 0; o < NP; o++) chk("mid_rst_data", 64'(odata[o]), 64'(0));
        rst_n = 1'b1;
        iv = '0;
        repeat (4) begin
            step();
            chk("post_rst_quiet", 64'(bus.out_valid), 64'(0));
        end

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            iv = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                idata[p] = $urandom;
                ofull[p] = ($urandom_range(0, 3) == 0);
            end
            step();
        end
        iv = '0;
        ofull = '0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
